// File: rtl/clk_div_monitor.sv
// Period/lock checker for clk_div outputs, sampled in the master clk domain.
// Optional high-time (duty) check enabled by CLK_DIV_MON_DUTY_EN.
module clk_div_monitor #(
  parameter int              NCH      = 5,
  parameter int              PW       = 8,
  parameter logic [NCH*PW-1:0] EXP_P  = {8'd8, 8'd6, 8'd4, 8'd3, 8'd2},
  parameter int              LOCK_CNT = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] div_in,
  input  logic           err_clr,
  input  logic [2:0]     mon_sel,
  output logic [NCH-1:0] locked,
  output logic [NCH-1:0] err,
  output logic           all_locked,
  output logic [PW-1:0]  mon_period
`ifdef CLK_DIV_MON_DUTY_EN
  ,
  output logic [NCH-1:0] duty_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEAS,
    S_LOCK
  } state_t;

  state_t         st     [NCH];
  logic [PW-1:0]  cnt    [NCH];
  logic [PW-1:0]  period [NCH];
  logic [3:0]     match  [NCH];
  logic [NCH-1:0] d_q;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] ok;
  logic [NCH-1:0] tmo;
  logic [NCH-1:0] bad;

  assign rise = div_in & ~d_q;

`ifdef CLK_DIV_MON_DUTY_EN
  logic [PW-1:0]  hcnt [NCH];
  logic [NCH-1:0] duty_ok;
  logic [NCH-1:0] duty_bad;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [PW-1:0] EXP = EXP_P[PW*i +: PW];
    localparam logic [PW:0]   TMO = {EXP, 1'b0};
`ifdef CLK_DIV_MON_DUTY_EN
    localparam logic [PW:0]   HLO = {1'b0, EXP} >> 1;
    localparam logic [PW:0]   HHI = ({1'b0, EXP} + 1'b1) >> 1;
    assign duty_ok[i]  = ({1'b0, hcnt[i]} == HLO) ||
                         ({1'b0, hcnt[i]} == HHI);
    assign ok[i]       = (cnt[i] == EXP) && duty_ok[i];
    assign duty_bad[i] = (st[i] == S_LOCK) && rise[i] && !duty_ok[i];
`else
    assign ok[i]  = (cnt[i] == EXP);
`endif
    // stall: no edge within twice the expected period
    assign tmo[i] = (st[i] != S_IDLE) && !rise[i] &&
                    ({1'b0, cnt[i]} == TMO);
    assign bad[i] = (st[i] == S_LOCK) &&
                    ((rise[i] && !ok[i]) || tmo[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_q        <= '0;
      locked     <= '0;
      err        <= '0;
      all_locked <= 1'b0;
`ifdef CLK_DIV_MON_DUTY_EN
      duty_err   <= '0;
`endif
      for (int i = 0; i < NCH; i++) begin
        st[i]     <= S_IDLE;
        cnt[i]    <= '0;
        period[i] <= '0;
        match[i]  <= '0;
`ifdef CLK_DIV_MON_DUTY_EN
        hcnt[i]   <= '0;
`endif
      end
    end else begin
      d_q        <= div_in;
      all_locked <= &locked;
      // a new error outranks a simultaneous clear
      err        <= (err & ~{NCH{err_clr}}) | bad;
`ifdef CLK_DIV_MON_DUTY_EN
      duty_err   <= (duty_err & ~{NCH{err_clr}}) | duty_bad;
`endif
      for (int i = 0; i < NCH; i++) begin
        if (rise[i]) begin
          cnt[i] <= PW'(1);
        end else if (cnt[i] != '1) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
`ifdef CLK_DIV_MON_DUTY_EN
        if (rise[i]) begin
          hcnt[i] <= PW'(1);
        end else if (div_in[i] && hcnt[i] != '1) begin
          hcnt[i] <= hcnt[i] + 1'b1;
        end
`endif
        if (rise[i]) begin
          unique case (st[i])
            S_IDLE: begin
              st[i]    <= S_MEAS;
              match[i] <= '0;
            end
            S_MEAS: begin
              period[i] <= cnt[i];
              if (!ok[i]) begin
                match[i] <= '0;
              end else if (match[i] == 4'(LOCK_CNT - 1)) begin
                st[i]     <= S_LOCK;
                locked[i] <= 1'b1;
                match[i]  <= '0;
              end else begin
                match[i] <= match[i] + 1'b1;
              end
            end
            S_LOCK: begin
              period[i] <= cnt[i];
              if (!ok[i]) begin
                st[i]     <= S_MEAS;
                locked[i] <= 1'b0;
                match[i]  <= '0;
              end
            end
            default: st[i] <= S_IDLE;
          endcase
        end else if (tmo[i]) begin
          st[i]     <= S_IDLE;
          locked[i] <= 1'b0;
          match[i]  <= '0;
        end
      end
    end
  end

  always_comb begin
    mon_period = '0;
    for (int i = 0; i < NCH; i++) begin
      if (mon_sel == 3'(i)) mon_period = period[i];
    end
  end

endmodule
